// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between instruction fetch and data access to one fixed-latency RAM port
//   clk, reset (sync, active-low)
//   i_req/i_addr -> i_ack        : fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_ack : load/store requester
//   rdata_o                      : read data for the acked requester, held until the next read
//   we_o/addr_o/data_o, data_i   : RAM port, read data valid LAT cycles after the address
//   busy_o                       : transaction in progress
module mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] rdata_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d;
  logic [3:0] cnt_q, cnt_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, we_q, we_d, busy_q, busy_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic win_d;
  // grant_q doubles as last_grant (1 = data); data wins unless fetch also asks and data won last time
  assign win_d = d_req & (~i_req | ~grant_q);
  // the ACCESS-cycle bus registers are the latch for the granted request
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    addr_d = '0;
    data_d = '0;
    we_d = 1'b0;
    case (state_q)
      IDLE: if (i_req | d_req) begin
        state_d = ACCESS;
        grant_d = win_d;
        addr_d = win_d ? d_addr : i_addr;
        data_d = win_d ? d_wdata : '0;
        we_d = win_d & d_we;
      end
      ACCESS: begin
        state_d = we_q ? RESP : WAIT;
        cnt_d = we_q ? cnt_q : LAT[3:0];
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? RESP : WAIT;
        rdata_d = (cnt_q == 4'd1) ? data_i : rdata_q;
      end
      default: state_d = IDLE;
    endcase
    // RESP is only ever entered for a single cycle, so entering it is the ack
    i_ack_d = (state_d == RESP) & ~grant_q;
    d_ack_d = (state_d == RESP) & grant_q;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      cnt_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      we_q <= we_d;
      busy_q <= busy_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rdata_q <= rdata_d;
    end
  end
  assign i_ack = i_ack_q;
  assign d_ack = d_ack_q;
  assign we_o = we_q;
  assign busy_o = busy_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter (LAT=1 main instance, LAT=3 latency instance)
module tb_mem_arbiter;
  localparam int LAT = 1;
  logic clk = 0;
  logic reset = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, data_i = 0;
  logic i_ack, d_ack, we_o, busy_o;
  logic [31:0] rdata_o, addr_o, data_o;
  logic reset3 = 0;
  logic i3_req = 0, d3_req = 0, d3_we = 0;
  logic [31:0] i3_addr = 0, d3_addr = 0, d3_wdata = 0, data3_i = 0;
  logic i3_ack, d3_ack, we3, busy3;
  logic [31:0] rdata3, addr3, data3_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata_o(rdata_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
    .busy_o(busy_o)
  );
  mem_arbiter #(.LAT(3)) dut3 (
    .clk(clk), .reset(reset3), .i_req(i3_req), .i_addr(i3_addr), .i_ack(i3_ack),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata), .d_ack(d3_ack),
    .rdata_o(rdata3), .we_o(we3), .addr_o(addr3), .data_o(data3_o), .data_i(data3_i),
    .busy_o(busy3)
  );
  // Reference model: each granted transaction is a schedule (grant cycle s, ack cycle e);
  // expected outputs for the coming cycle are derived from where that cycle falls in the schedule.
  int cyc = 0, t_s = 0, t_e = 0;
  bit t_valid = 0, t_data = 0, t_store = 0, last_data = 1;
  logic [31:0] t_addr = 0, t_wdata = 0, m_rdata = 0;
  logic exp_busy = 0, exp_iack = 0, exp_dack = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_data = 0;
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      t_valid = 0;
      t_e = cyc;
      last_data = 1;
      m_rdata = 0;
    end else begin
      if (t_valid && !t_store && cyc == t_e - 1) m_rdata = data_i;
      if (cyc > t_e && (i_req || d_req)) begin
        t_data = d_req && (!i_req || !last_data);
        last_data = t_data;
        t_store = t_data && d_we;
        t_addr = t_data ? d_addr : i_addr;
        t_wdata = t_data ? d_wdata : 32'h0;
        t_s = cyc;
        t_e = cyc + (t_store ? 2 : 2 + LAT);
        t_valid = 1;
      end
    end
    cyc++;
    exp_busy = t_valid && cyc > t_s && cyc <= t_e;
    exp_we = t_valid && cyc == t_s + 1 && t_store;
    exp_addr = (t_valid && cyc == t_s + 1) ? t_addr : 32'h0;
    exp_data = (t_valid && cyc == t_s + 1) ? t_wdata : 32'h0;
    exp_iack = t_valid && cyc == t_e && !t_data;
    exp_dack = t_valid && cyc == t_e && t_data;
  end
  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    i_req = 0;
    d_req = 0;
    @(negedge clk);
    reset = 1;
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({busy_o, i_ack, d_ack, we_o} !== 4'b0) begin
        errors++;
        $display("FAIL reset_ctl got %b want 0000", {busy_o, i_ack, d_ack, we_o});
      end
      checks++;
      if (addr_o !== 32'h0 || data_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_bus got addr %h data %h want 0 0", addr_o, data_o);
      end
      checks++;
      if (rdata_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata got %h want 0", rdata_o);
      end
      i_req = 1;
      d_req = 1;
      d_we = 1;
      i_addr = $urandom;
      d_addr = $urandom;
    end
    reset = 1;
    i_req = 0;
    d_req = 0;
  endtask
  task automatic test_fetch();
    @(negedge clk);
    i_req = 1;
    i_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (addr_o !== 32'h100 || we_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_access got addr %h we %b busy %b want 100 0 1", addr_o, we_o, busy_o);
    end
    data_i = $urandom;
    @(negedge clk);
    checks++;
    if (addr_o !== 32'h0 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait got addr %h ack %b want 0 0", addr_o, i_ack);
    end
    data_i = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_ack got iack %b dack %b rdata %h want 1 0 deadbeef", i_ack, d_ack, rdata_o);
    end
    i_req = 0;
    data_i = $urandom;
  endtask
  task automatic test_store();
    @(negedge clk);
    d_req = 1;
    d_we = 1;
    d_addr = 32'h40;
    d_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (we_o !== 1'b1 || addr_o !== 32'h40 || data_o !== 32'h12345678 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL store_access got we %b addr %h data %h ack %b want 1 40 12345678 0", we_o, addr_o, data_o, d_ack);
    end
    data_i = $urandom;
    @(negedge clk);
    checks++;
    if (we_o !== 1'b0 || addr_o !== 32'h0 || data_o !== 32'h0 || d_ack !== 1'b1 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL store_ack got we %b addr %h data %h dack %b iack %b want 0 0 0 1 0", we_o, addr_o, data_o, d_ack, i_ack);
    end
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_rdata got %h want deadbeef", rdata_o);
    end
    d_req = 0;
    d_we = 0;
  endtask
  task automatic test_conflict();
    int seq = 0;
    do_reset();
    @(negedge clk);
    i_req = 1;
    i_addr = 32'h200;
    d_req = 1;
    d_we = 0;
    d_addr = 32'h300;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (i_ack && d_ack) begin
        errors++;
        $display("FAIL conflict_overlap got both acks at %0d want one", k);
      end
      if (i_ack) seq = seq * 4 + 1;
      if (d_ack) seq = seq * 4 + 2;
      if (k == 1 || k == 5 || k == 9) begin
        checks++;
        if (addr_o !== ((k == 5) ? 32'h300 : 32'h200)) begin
          errors++;
          $display("FAIL conflict_order got addr %h at %0d want %h", addr_o, k, (k == 5) ? 32'h300 : 32'h200);
        end
      end
      if (k == 12) begin
        i_req = 0;
        d_req = 0;
      end
    end
    checks++;
    if (seq != 25) begin
      errors++;
      $display("FAIL conflict_seq got %0d want 25 (fetch,data,fetch)", seq);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    d_req = 1;
    d_we = 0;
    d_addr = 32'h55;
    @(negedge clk);
    checks++;
    if (addr_o !== 32'h55) begin
      errors++;
      $display("FAIL rstmid_access got %h want 55", addr_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wait got busy %b want 1", busy_o);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if ({busy_o, i_ack, d_ack, we_o} !== 4'b0 || addr_o !== 32'h0 || data_o !== 32'h0 || rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_clear got ctl %b addr %h data %h rdata %h want all 0", {busy_o, i_ack, d_ack, we_o}, addr_o, data_o, rdata_o);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (addr_o !== 32'h55 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_replay got addr %h busy %b want 55 1", addr_o, busy_o);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ack got %b want 1", d_ack);
    end
    d_req = 0;
  endtask
  task automatic test_addr_change();
    @(negedge clk);
    i_req = 1;
    i_addr = 32'hA0;
    @(negedge clk);
    checks++;
    if (addr_o !== 32'hA0) begin
      errors++;
      $display("FAIL addrchg_access got %h want a0", addr_o);
    end
    i_addr = 32'hB0;
    @(negedge clk);
    checks++;
    if (addr_o !== 32'h0) begin
      errors++;
      $display("FAIL addrchg_wait got %h want 0", addr_o);
    end
    @(negedge clk);
    checks++;
    if (addr_o !== 32'h0 || i_ack !== 1'b1) begin
      errors++;
      $display("FAIL addrchg_ack got addr %h ack %b want 0 1", addr_o, i_ack);
    end
    i_req = 0;
  endtask
  task automatic test_lat3();
    @(negedge clk);
    reset3 = 1;
    d3_req = 1;
    d3_we = 0;
    d3_addr = 32'h80;
    data3_i = $urandom;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (d3_ack !== (k == 5) || i3_ack !== 1'b0 || busy3 !== (k <= 5)) begin
        errors++;
        $display("FAIL lat3_ctl at %0d got dack %b iack %b busy %b want %b 0 %b", k, d3_ack, i3_ack, busy3, k == 5, k <= 5);
      end
      if (k == 1) begin
        checks++;
        if (addr3 !== 32'h80) begin
          errors++;
          $display("FAIL lat3_access got %h want 80", addr3);
        end
      end
      if (k == 5) begin
        checks++;
        if (rdata3 !== 32'hCAFEF00D) begin
          errors++;
          $display("FAIL lat3_rdata got %h want cafef00d", rdata3);
        end
        d3_req = 0;
      end
      data3_i = (k == 4) ? 32'hCAFEF00D : $urandom;
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++;
      if ({busy_o, i_ack, d_ack, we_o, addr_o, data_o, rdata_o} !==
          {exp_busy, exp_iack, exp_dack, exp_we, exp_addr, exp_data, m_rdata}) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h", k,
                 {busy_o, i_ack, d_ack, we_o, addr_o, data_o, rdata_o},
                 {exp_busy, exp_iack, exp_dack, exp_we, exp_addr, exp_data, m_rdata});
      end
      reset = $urandom_range(0, 63) != 0;
      i_req = $urandom_range(0, 2) == 0;
      d_req = $urandom_range(0, 2) == 0;
      d_we = $urandom_range(0, 1) == 1;
      i_addr = $urandom;
      d_addr = $urandom;
      d_wdata = $urandom;
      data_i = $urandom;
    end
    reset = 1;
    i_req = 0;
    d_req = 0;
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_conflict();
    test_reset_mid();
    test_addr_change();
    test_lat3();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
